// File: rtl/sd_burst_gather.sv
// Burst gatherer: holds a FIFO's output closed until `burst` words are buffered, then
// forwards them as one framed burst. Optional timeout flush via SD_BURST_GATHER_TMO_EN.
module sd_burst_gather #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int usz   = $clog2(depth + 1),
    parameter int burst = 4,
    parameter int bsz   = $clog2(burst + 1),
    parameter int tmo   = 32,
    parameter int tsz   = $clog2(tmo + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] c_data,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [usz-1:0]   c_usage,
    output logic [width-1:0] p_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic             p_last,
    output logic [bsz-1:0]   p_len
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [usz-1:0] BURST_U = usz'(burst);
    localparam logic [bsz-1:0] BURST_B = bsz'(burst);

    state_t         state_q, state_d;
    logic [bsz-1:0] remain_q, remain_d;
    logic [bsz-1:0] p_len_q, p_len_d;
    logic           full_start;
    logic           tmo_start;

    assign full_start = (c_usage >= BURST_U);

`ifdef SD_BURST_GATHER_TMO_EN
    localparam logic [tsz-1:0] TMO_T = tsz'(tmo);

    logic [tsz-1:0] timer_q, timer_d;
    logic           partial;

    assign partial   = (c_usage != '0) && !full_start;
    assign tmo_start = partial && (timer_q == TMO_T);

    // Counts only while a short fill waits in IDLE; saturates so the flush stays armed.
    always_comb begin
        timer_d = '0;
        if (state_q == IDLE && partial) begin
            timer_d = (timer_q == TMO_T) ? timer_q : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic [tsz-1:0] unused_tmo_cfg;

    assign tmo_start      = 1'b0;
    assign unused_tmo_cfg = tsz'(tmo);
`endif

    assign p_data = c_data;
    assign p_len  = p_len_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        p_len_d  = p_len_q;
        c_drdy   = 1'b0;
        p_srdy   = 1'b0;
        p_last   = 1'b0;
        case (state_q)
            IDLE: begin
                // A full burst takes priority over a simultaneous timeout.
                if (full_start) begin
                    state_d  = BURST;
                    remain_d = BURST_B;
                    p_len_d  = BURST_B;
                end else if (tmo_start) begin
                    state_d  = BURST;
                    remain_d = c_usage[bsz-1:0];
                    p_len_d  = c_usage[bsz-1:0];
                end
            end
            BURST: begin
                p_srdy = c_srdy;
                c_drdy = p_drdy;
                p_last = (remain_q == bsz'(1));
                if (c_srdy && p_drdy) begin
                    remain_d = remain_q - 1'b1;
                    if (p_last) begin
                        state_d = IDLE;
                        p_len_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            p_len_q  <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            p_len_q  <= p_len_d;
        end
    end

endmodule
